stk_pipe_wrbk_buf: RTL and testbench

// - Next-generation STK writeback stage. Takes the WRBK microcode beat and

---
 rtl/stk_pipe_wrbk_buf.sv | 107 ++++++++++
 tb/tb_stk_pipe_wrbk_buf.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stk_pipe_wrbk_buf.sv
// STK writeback buffer: routes each WRBK beat into a per-engine response FIFO drained by valid/ready.
// Optional same-cycle bypass into an empty queue: define STK_PIPE_WRBK_BUF_BYPASS_EN.
module stk_pipe_wrbk_buf #(
    parameter int ENGS_N   = 4,
    parameter int DAT_W    = 128,
    parameter int DEPTH    = 2,
    parameter int STATUS_W = 4,
    localparam int ENG_W   = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int PTR_W   = IDX_W + 1,
    localparam int ENT_W   = STATUS_W + DAT_W
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       i_wrbk_uc_vld_r,
    input  logic [ENG_W-1:0]           i_wrbk_uc_engid_r,
    input  logic [STATUS_W-1:0]        i_wrbk_uc_status_r,
    input  logic [DAT_W-1:0]           i_wrbk_uc_dat_r,
    input  logic                       i_wrbk_rsp_inv_kill,
    input  logic [ENGS_N-1:0]          i_rsp_rdy,
    output logic [ENGS_N-1:0]          o_rsp_vld,
    output logic [ENGS_N*DAT_W-1:0]    o_rsp_dat,
    output logic [ENGS_N*STATUS_W-1:0] o_rsp_status,
    output logic [ENGS_N-1:0]          o_eng_full,
    output logic                       o_err_ovf
);

    localparam logic [ENG_W:0] ENGS_L = (ENG_W+1)'(ENGS_N);

    logic [PTR_W-1:0]  wr_ptr [ENGS_N];
    logic [PTR_W-1:0]  rd_ptr [ENGS_N];
    logic [ENT_W-1:0]  mem    [ENGS_N][DEPTH];

    logic [ENGS_N-1:0] empty, full, enq_hit, byp, vld, pop, wr_en;
    logic              enq, bad_eng, ovf_hit;
    logic [ENT_W-1:0]  beat, head;

    assign beat = {i_wrbk_uc_status_r, i_wrbk_uc_dat_r};

    always_comb begin
        enq          = i_wrbk_uc_vld_r & ~i_wrbk_rsp_inv_kill;
        bad_eng      = {1'b0, i_wrbk_uc_engid_r} >= ENGS_L;
        ovf_hit      = enq & bad_eng;
        empty        = '0;
        full         = '0;
        enq_hit      = '0;
        byp          = '0;
        vld          = '0;
        pop          = '0;
        wr_en        = '0;
        head         = '0;
        o_rsp_dat    = '0;
        o_rsp_status = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            empty[e]   = (wr_ptr[e] == rd_ptr[e]);
            full[e]    = (wr_ptr[e][IDX_W-1:0] == rd_ptr[e][IDX_W-1:0]) &&
                         (wr_ptr[e][PTR_W-1] != rd_ptr[e][PTR_W-1]);
            enq_hit[e] = enq & ~bad_eng & (i_wrbk_uc_engid_r == ENG_W'(e));
`ifdef STK_PIPE_WRBK_BUF_BYPASS_EN
            byp[e]     = enq_hit[e] & empty[e];
`else
            byp[e]     = 1'b0;
`endif
            vld[e]     = ~empty[e] | byp[e];
            pop[e]     = ~empty[e] & i_rsp_rdy[e];
            // A full queue still accepts a beat when its head leaves this cycle;
            // a bypassed beat taken immediately is never stored.
            wr_en[e]   = enq_hit[e] & (~full[e] | pop[e]) & ~(byp[e] & i_rsp_rdy[e]);
            ovf_hit    = ovf_hit | (enq_hit[e] & full[e] & ~pop[e]);
            if (byp[e])
                head = beat;
            else if (!empty[e])
                head = mem[e][rd_ptr[e][IDX_W-1:0]];
            else
                head = '0;
            o_rsp_dat[e*DAT_W +: DAT_W]          = head[DAT_W-1:0];
            o_rsp_status[e*STATUS_W +: STATUS_W] = head[DAT_W +: STATUS_W];
        end
    end

    assign o_rsp_vld  = vld;
    assign o_eng_full = full;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int e = 0; e < ENGS_N; e++) begin
                wr_ptr[e] <= '0;
                rd_ptr[e] <= '0;
            end
            o_err_ovf <= 1'b0;
        end else begin
            for (int e = 0; e < ENGS_N; e++) begin
                if (wr_en[e]) wr_ptr[e] <= wr_ptr[e] + PTR_W'(1);
                if (pop[e])   rd_ptr[e] <= rd_ptr[e] + PTR_W'(1);
            end
            if (ovf_hit) o_err_ovf <= 1'b1;
        end
    end

    // Entry storage carries no reset; stale entries are masked by the empty flag.
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENGS_N; e++) begin
            if (wr_en[e]) mem[e][wr_ptr[e][IDX_W-1:0]] <= beat;
        end
    end

endmodule

// File: tb/tb_stk_pipe_wrbk_buf.sv
// Bench for stk_pipe_wrbk_buf: directed scenarios plus random traffic against a queue-based model.
module tb_stk_pipe_wrbk_buf;
    localparam int ENGS_N   = 4;
    localparam int DAT_W    = 128;
    localparam int DEPTH    = 2;
    localparam int STATUS_W = 4;
    localparam int ENT_W    = DAT_W + STATUS_W;
`ifdef STK_PIPE_WRBK_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       arst;
    logic                       i_wrbk_uc_vld_r;
    logic [1:0]                 i_wrbk_uc_engid_r;
    logic [STATUS_W-1:0]        i_wrbk_uc_status_r;
    logic [DAT_W-1:0]           i_wrbk_uc_dat_r;
    logic                       i_wrbk_rsp_inv_kill;
    logic [ENGS_N-1:0]          i_rsp_rdy;
    logic [ENGS_N-1:0]          o_rsp_vld;
    logic [ENGS_N*DAT_W-1:0]    o_rsp_dat;
    logic [ENGS_N*STATUS_W-1:0] o_rsp_status;
    logic [ENGS_N-1:0]          o_eng_full;
    logic                       o_err_ovf;

    int checks   = 0;
    int failures = 0;

    logic [ENT_W-1:0] q [ENGS_N][$];
    logic             err_m;

    stk_pipe_wrbk_buf #(
        .ENGS_N(ENGS_N), .DAT_W(DAT_W), .DEPTH(DEPTH), .STATUS_W(STATUS_W)
    ) dut (
        .clk                (clk),
        .arst               (arst),
        .i_wrbk_uc_vld_r    (i_wrbk_uc_vld_r),
        .i_wrbk_uc_engid_r  (i_wrbk_uc_engid_r),
        .i_wrbk_uc_status_r (i_wrbk_uc_status_r),
        .i_wrbk_uc_dat_r    (i_wrbk_uc_dat_r),
        .i_wrbk_rsp_inv_kill(i_wrbk_rsp_inv_kill),
        .i_rsp_rdy          (i_rsp_rdy),
        .o_rsp_vld          (o_rsp_vld),
        .o_rsp_dat          (o_rsp_dat),
        .o_rsp_status       (o_rsp_status),
        .o_eng_full         (o_eng_full),
        .o_err_ovf          (o_err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [ENT_W-1:0] slice(input int e);
        return {o_rsp_status[e*STATUS_W +: STATUS_W], o_rsp_dat[e*DAT_W +: DAT_W]};
    endfunction

    function automatic logic [DAT_W-1:0] rnd_dat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int e = 0; e < ENGS_N; e++) q[e].delete();
        err_m = 1'b0;
    endtask

    // Drive one beat at the falling edge, check outputs against the model, then advance one clock.
    task automatic step(input logic v, input logic [1:0] id, input logic [STATUS_W-1:0] st,
                        input logic [DAT_W-1:0] d, input logic k, input logic [ENGS_N-1:0] r);
        logic [ENGS_N-1:0] exp_v, exp_f;
        logic [ENT_W-1:0]  exp_h;
        logic              enq_e, empty0, full0, popped;
        i_wrbk_uc_vld_r     = v;
        i_wrbk_uc_engid_r   = id;
        i_wrbk_uc_status_r  = st;
        i_wrbk_uc_dat_r     = d;
        i_wrbk_rsp_inv_kill = k;
        i_rsp_rdy           = r;
        #1;
        for (int e = 0; e < ENGS_N; e++) begin
            enq_e    = v && !k && (id == 2'(e));
            exp_v[e] = (q[e].size() > 0) || (BYP && enq_e);
            exp_f[e] = (q[e].size() == DEPTH);
            if (q[e].size() > 0)  exp_h = q[e][0];
            else if (exp_v[e])    exp_h = {st, d};
            else                  exp_h = '0;
            chk($sformatf("head%0d", e), 160'(slice(e)), 160'(exp_h));
        end
        chk("vld", 160'(o_rsp_vld), 160'(exp_v));
        chk("full", 160'(o_eng_full), 160'(exp_f));
        chk("err", 160'(o_err_ovf), 160'(err_m));
        @(posedge clk);
        for (int e = 0; e < ENGS_N; e++) begin
            enq_e  = v && !k && (id == 2'(e));
            empty0 = (q[e].size() == 0);
            full0  = (q[e].size() == DEPTH);
            popped = 1'b0;
            if (exp_v[e] && r[e] && !empty0) begin
                void'(q[e].pop_front());
                popped = 1'b1;
            end
            if (enq_e) begin
                if (BYP && empty0 && r[e]) ;
                else if (!full0 || popped) q[e].push_back({st, d});
                else err_m = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [ENGS_N-1:0] r);
        step(1'b0, 2'd0, '0, '0, 1'b0, r);
    endtask

    logic [DAT_W-1:0] da, db, dc;

    initial begin
        arst = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            i_wrbk_uc_vld_r     = 1'($urandom);
            i_wrbk_uc_engid_r   = 2'($urandom);
            i_wrbk_uc_status_r  = 4'($urandom);
            i_wrbk_uc_dat_r     = rnd_dat();
            i_wrbk_rsp_inv_kill = 1'($urandom);
            i_rsp_rdy           = 4'($urandom);
            @(posedge clk);
            #1;
            chk("rst_vld", 160'(o_rsp_vld), 160'(0));
            chk("rst_full", 160'(o_eng_full), 160'(0));
            chk("rst_err", 160'(o_err_ovf), 160'(0));
            chk("rst_dat", 160'(o_rsp_dat[DAT_W-1:0]), 160'(0));
        end
        @(negedge clk);
        arst = 1'b0;

        // Basic routing to engine 2
        step(1'b1, 2'd2, 4'h1, 128'hDEAD_BEEF, 1'b0, 4'b0000);
        chk("route_vld", 160'(o_rsp_vld), 160'(4'b0100));
        chk("route_head", 160'(slice(2)), 160'({4'h1, 128'hDEAD_BEEF}));
        idle(4'b0100);
        chk("route_pop", 160'(o_rsp_vld), 160'(4'b0000));

        // Killed beat leaves everything unchanged
        step(1'b1, 2'd1, 4'h3, 128'h1234, 1'b1, 4'b0000);
        chk("kill_vld", 160'(o_rsp_vld), 160'(4'b0000));

        // Fill engine 0, overflow, drain in order
        da = rnd_dat(); db = rnd_dat(); dc = rnd_dat();
        step(1'b1, 2'd0, 4'hA, da, 1'b0, 4'b0000);
        step(1'b1, 2'd0, 4'hB, db, 1'b0, 4'b0000);
        chk("fill_full", 160'(o_eng_full[0]), 160'(1));
        step(1'b1, 2'd0, 4'hC, dc, 1'b0, 4'b0000);
        chk("ovf_err", 160'(o_err_ovf), 160'(1));
        chk("ovf_head", 160'(slice(0)), 160'({4'hA, da}));
        idle(4'b0001);
        chk("drain_b", 160'(slice(0)), 160'({4'hB, db}));
        idle(4'b0001);
        chk("drain_empty", 160'(o_rsp_vld[0]), 160'(0));

        // Full queue 3 with simultaneous enqueue and dequeue
        step(1'b1, 2'd3, 4'h1, da, 1'b0, 4'b0000);
        step(1'b1, 2'd3, 4'h2, db, 1'b0, 4'b0000);
        step(1'b1, 2'd3, 4'h3, dc, 1'b0, 4'b1000);
        chk("sim_full", 160'(o_eng_full[3]), 160'(1));
        chk("sim_head", 160'(slice(3)), 160'({4'h2, db}));
        idle(4'b1000);
        chk("sim_next", 160'(slice(3)), 160'({4'h3, dc}));
        idle(4'b1000);

        // Parallel drain of all engines
        for (int e = 0; e < ENGS_N; e++) step(1'b1, 2'(e), 4'(e), rnd_dat(), 1'b0, 4'b0000);
        chk("par_vld", 160'(o_rsp_vld), 160'(4'b1111));
        idle(4'b1111);
        chk("par_pop", 160'(o_rsp_vld), 160'(4'b0000));

        // Same-cycle consumption when the bypass path is built in
        step(1'b1, 2'd0, 4'h5, da, 1'b0, 4'b0001);
        chk("byp_after", 160'(o_rsp_vld[0]), 160'(BYP ? 1'b0 : 1'b1));
        idle(4'b1111);

        // Asynchronous reset with entries queued
        step(1'b1, 2'd1, 4'h6, db, 1'b0, 4'b0000);
        #2;
        arst = 1'b1;
        #1;
        chk("arst_vld", 160'(o_rsp_vld), 160'(0));
        chk("arst_err", 160'(o_err_ovf), 160'(0));
        chk("arst_dat", 160'(slice(1)), 160'(0));
        @(negedge clk);
        arst = 1'b0;
        model_clear();

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), 2'($urandom), 4'($urandom), rnd_dat(),
                 ($urandom_range(0, 19) < 3), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
